// File: rtl/multicycle_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// multicycle_ctrl : multi-cycle IF/ID/EX/MEM/WB sequencer with memory handshake
// and retired-instruction counter for the R/I/J datapath.          Rev 1.0
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_alur,
  input  logic             is_aluimm,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ab_write,
  output logic             alu_out_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam int C_LOAD   = 0;
  localparam int C_STORE  = 1;
  localparam int C_ALUR   = 2;
  localparam int C_ALUIMM = 3;
  localparam int C_BRANCH = 4;
  localparam int C_JUMP   = 5;

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     cur;
  state_t     nxt;
  logic [5:0] flags;
  logic [5:0] cls;
  logic [5:0] cls_nxt;
  logic       flags_onehot;
  logic       retire;
  logic       jump_pc;

  assign flags        = {is_jump, is_branch, is_aluimm, is_alur, is_store, is_load};
  assign flags_onehot = (flags != 6'd0) && ((flags & (flags - 6'd1)) == 6'd0);

  // Next-state decode; retire collapses every instruction end onto IF/IDLE.
  always_comb begin
    nxt     = cur;
    cls_nxt = cls;
    retire  = 1'b0;
    case (cur)
      S_IDLE: if (run) nxt = S_IF;
      S_IF:   if (mem_ready) nxt = S_ID;
      S_ID: begin
        cls_nxt = flags;
        nxt     = flags_onehot ? S_EX : S_HALT;
      end
      S_EX: begin
        if (cls[C_LOAD] || cls[C_STORE])
          nxt = S_MEM;
        else if (cls[C_ALUR] || cls[C_ALUIMM])
          nxt = S_WB;
        else
          retire = 1'b1;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls[C_STORE]) retire = 1'b1;
          else              nxt    = S_WB;
        end
      end
      S_WB:   retire = 1'b1;
      S_HALT: nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
    if (retire) nxt = run ? S_IF : S_IDLE;
  end

  // Moore strobes are registered from the next state so they are glitch-free
  // and drop to zero together with the state on asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= S_IDLE;
      cls           <= 6'd0;
      retired       <= {CNT_W{1'b0}};
      illegal       <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      iord          <= 1'b0;
      ab_write      <= 1'b0;
      alu_out_write <= 1'b0;
      pc_write_cond <= 1'b0;
      reg_write     <= 1'b0;
      jump_pc       <= 1'b0;
    end else begin
      cur <= nxt;
      cls <= cls_nxt;
      if (cur == S_ID && !flags_onehot) illegal <= 1'b1;
      if (retire) retired <= retired + C_ONE;
      mem_req       <= (nxt == S_IF) || (nxt == S_MEM);
      mem_we        <= (nxt == S_MEM) && cls_nxt[C_STORE];
      iord          <= (nxt == S_MEM);
      ab_write      <= (nxt == S_ID);
      alu_out_write <= (nxt == S_EX);
      pc_write_cond <= (nxt == S_EX) && cls_nxt[C_BRANCH];
      reg_write     <= (nxt == S_WB);
      jump_pc       <= (nxt == S_EX) && cls_nxt[C_JUMP];
    end
  end

  // Completion strobes qualified by the memory handshake in the same cycle.
  assign ir_write  = (cur == S_IF) && mem_ready;
  assign pc_write  = jump_pc || ((cur == S_IF) && mem_ready);
  assign mdr_write = (cur == S_MEM) && cls[C_LOAD] && mem_ready;
  assign state     = cur;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl : randomized instruction streams checked cycle-by-cycle
// against a per-stage timing model derived from the instruction class rules.
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic mem_ready = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, is_alur = 1'b0;
  logic is_aluimm = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic ab_write, alu_out_write, mdr_write, reg_write, illegal;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .is_load(is_load), .is_store(is_store), .is_alur(is_alur),
    .is_aluimm(is_aluimm), .is_branch(is_branch), .is_jump(is_jump),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ab_write(ab_write), .alu_out_write(alu_out_write), .mdr_write(mdr_write),
    .reg_write(reg_write), .state(state), .retired(retired), .illegal(illegal)
  );

  localparam logic [10:0] M_REQ  = 11'b100_0000_0000;
  localparam logic [10:0] M_WE   = 11'b010_0000_0000;
  localparam logic [10:0] M_IORD = 11'b001_0000_0000;
  localparam logic [10:0] M_IRW  = 11'b000_1000_0000;
  localparam logic [10:0] M_PCW  = 11'b000_0100_0000;
  localparam logic [10:0] M_PCC  = 11'b000_0010_0000;
  localparam logic [10:0] M_AB   = 11'b000_0001_0000;
  localparam logic [10:0] M_ALU  = 11'b000_0000_1000;
  localparam logic [10:0] M_MDR  = 11'b000_0000_0100;
  localparam logic [10:0] M_RW   = 11'b000_0000_0010;
  localparam logic [10:0] M_ILL  = 11'b000_0000_0001;
  localparam logic [10:0] M_NONE = 11'b0;

  typedef struct packed {
    logic [2:0]  st;
    logic [10:0] strb;
    logic        rdy;
    logic        run;
    logic [5:0]  flags;
    logic [3:0]  ret;
  } cyc_t;

  cyc_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt = 0;
  logic ill = 1'b0;
  int   cur_idx = 0;
  int   cur_drop = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {14'b0, state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
            ab_write, alu_out_write, mdr_write, reg_write, illegal, retired};
  endfunction

  function automatic logic [5:0] rnd_flags();
    return 6'($urandom);
  endfunction

  // rdy < 0 means "don't care": a random value the DUT must ignore.
  task automatic push(input logic [2:0] st, input logic [10:0] strb, input int rdy,
                      input logic [5:0] fl);
    cyc_t e;
    e.st    = st;
    e.strb  = strb | (ill ? M_ILL : M_NONE);
    e.rdy   = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
    e.run   = !(cur_drop >= 0 && cur_idx >= cur_drop);
    e.flags = fl;
    e.ret   = 4'(cnt);
    q.push_back(e);
    cur_idx++;
  endtask

  task automatic idle();
    cur_drop = -1;
    push(3'd0, M_NONE, -1, rnd_flags());
  endtask

  // Class c: 0 load, 1 store, 2 alur, 3 aluimm, 4 branch, 5 jump.
  // drop: cycle index within the instruction from which run is held low.
  task automatic add_instr(input int c, input int ifw, input int mw, input int drop);
    logic [5:0] oh;
    bit mem, wb;
    int len;
    oh  = 6'b1 << c;
    mem = (c <= 1);
    wb  = (c == 0 || c == 2 || c == 3);
    len = ifw + 3 + (mem ? mw + 1 : 0) + (wb ? 1 : 0);
    cur_idx  = 0;
    cur_drop = drop;
    for (int k = 0; k <= ifw; k++)
      push(3'd1, M_REQ | ((k == ifw) ? (M_IRW | M_PCW) : M_NONE), (k == ifw) ? 1 : 0, rnd_flags());
    push(3'd2, M_AB, -1, oh);
    push(3'd3, M_ALU | ((c == 4) ? M_PCC : M_NONE) | ((c == 5) ? M_PCW : M_NONE), -1, rnd_flags());
    if (mem)
      for (int k = 0; k <= mw; k++)
        push(3'd4, M_REQ | M_IORD | ((c == 1) ? M_WE : M_NONE) |
                   ((k == mw && c == 0) ? M_MDR : M_NONE), (k == mw) ? 1 : 0, rnd_flags());
    if (wb) push(3'd5, M_RW, -1, rnd_flags());
    cnt = (cnt + 1) % 16;
    if (drop >= 0 && drop < len) idle();
    cur_drop = -1;
  endtask

  task automatic add_illegal(input logic [5:0] fl, input int ifw);
    cur_idx  = 0;
    cur_drop = -1;
    for (int k = 0; k <= ifw; k++)
      push(3'd1, M_REQ | ((k == ifw) ? (M_IRW | M_PCW) : M_NONE), (k == ifw) ? 1 : 0, rnd_flags());
    push(3'd2, M_AB, -1, fl);
    ill = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cur_drop = ($urandom_range(0, 1) == 1) ? 0 : -1;
      push(3'd6, M_NONE, -1, rnd_flags());
    end
    cur_drop = -1;
  endtask

  task automatic drive(input int n);
    int   lim;
    cyc_t e;
    lim = (n < 0 || n > q.size()) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      e = q[i];
      @(posedge clk);
      #1;
      run       = e.run;
      mem_ready = e.rdy;
      {is_jump, is_branch, is_aluimm, is_alur, is_store, is_load} = e.flags;
      @(negedge clk);
      check($sformatf("cycle st=%0d", e.st), obs(), {14'b0, e.st, e.strb, e.ret});
    end
    q.delete();
  endtask

  // Asserts reset between edges and checks outputs clear with no clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    #1 check("async_reset", obs(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    ill = 1'b0;
  endtask

  initial begin
    do_reset();
    idle();
    add_instr(2, 0, 0, -1);
    add_instr(0, 2, 3, -1);
    add_instr(1, 0, 0, -1);
    add_instr(4, 0, 0, -1);
    add_instr(5, 0, 0, 2);
    drive(-1);

    do_reset();
    idle();
    for (int i = 0; i < 16; i++) add_instr(2, 0, 0, -1);
    add_instr(2, 0, 0, 2);
    drive(-1);

    for (int i = 0; i < 40; i++) begin
      int c, ifw, mw, drop;
      c    = int'($urandom_range(0, 5));
      ifw  = int'($urandom_range(0, 3));
      mw   = int'($urandom_range(0, 3));
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      add_instr(c, ifw, mw, drop);
    end
    add_instr(2, 0, 0, 3);
    drive(-1);

    do_reset();
    idle();
    add_instr(2, 0, 0, -1);
    add_illegal(6'b000000, 1);
    drive(-1);
    do_reset();
    idle();
    add_illegal(6'b000011, 0);
    drive(-1);
    do_reset();

    idle();
    add_instr(2, 0, 0, -1);
    add_instr(0, 0, 5, -1);
    drive(10);
    do_reset();
    idle();
    add_instr(3, 1, 0, 4);
    drive(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the R/I/J CPU datapath. It takes the one-hot instruction class produced by the instruction analyser (load, store, ALU-R, ALU-immediate, branch, jump) and walks the shared datapath through fetch, decode, execute, memory and write-back. It issues every register-enable, memory-request and PC-update strobe, handshakes with a variable-latency memory, and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: allows fetching of new instructions.
- `is_load`, `is_store`, `is_alur`, `is_aluimm`, `is_branch`, `is_jump` input 1 each: class flags decoded from the current IR.
- `mem_ready` input 1: memory completes the pending request this cycle.
- `mem_req` output 1: memory request.
- `mem_we` output 1: the request is a write.
- `iord` output 1: memory address select (0 = PC, 1 = ALU out).
- `ir_write` output 1: load IR.
- `pc_write` output 1: unconditional PC update.
- `pc_write_cond` output 1: PC update if the branch is taken (the datapath qualifies with ZF).
- `ab_write` output 1: latch the register-file outputs into A/B.
- `alu_out_write` output 1: latch the ALU result.
- `mdr_write` output 1: latch memory read data.
- `reg_write` output 1: register-file write.
- `state` output 3: current state encoding.
- `retired` output CNT_W: retired-instruction count.
- `illegal` output 1: sticky illegal-class flag.

## Operation
State encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and must be treated as HALT.

- **IDLE**: all strobes 0. Go to IF when `run`=1.
- **IF**:
  - `mem_req`=1, `iord`=0, `mem_we`=0.
  - Hold until `mem_ready`=1.
  - In the `mem_ready` cycle: `ir_write`=1 and `pc_write`=1 (PC+4), then go to ID.
- **ID**:
  - `ab_write`=1.
  - Sample the six class flags into an internal class register.
  - If exactly one flag is set, go to EX.
  - If zero or more than one flag is set, set `illegal`, go to HALT, and leave `retired` unchanged.
- **EX**: `alu_out_write`=1. Next state depends on the latched class:
  - load/store: go to MEM.
  - alur/aluimm: go to WB.
  - branch: `pc_write_cond`=1, then retire.
  - jump: `pc_write`=1, then retire.
- **MEM**:
  - `mem_req`=1, `iord`=1, `mem_we`=1 only for store.
  - Hold until `mem_ready`=1.
  - Load: `mdr_write`=1 in the ready cycle, then go to WB.
  - Store: retire in the ready cycle.
- **WB**: `reg_write`=1, then retire.
- **Retire**:
  - `retired` increments by 1 on the same edge as the state exit. It wraps modulo 2^CNT_W.
  - Next state is IF if `run`=1 at that edge, otherwise IDLE.
- **HALT**: all strobes 0. Exit only through reset.

General rules:
- `mem_ready` is ignored in every state where `mem_req`=0.
- Class flags are ignored outside ID. Only the latched class steers EX and MEM.
- Deasserting `run` mid-instruction does not abort it. The instruction completes and retires, then the block goes to IDLE.

## Timing
- Reset (asynchronous assert):
  - `state`=IDLE, `retired`=0, `illegal`=0, class register cleared.
  - All strobes 0 immediately, with no clock needed.
  - Reset deassertion takes effect at the next clock edge.
- Strobe timing:
  - `mem_req`, `mem_we`, `iord`, `ab_write`, `alu_out_write`, `reg_write` and `pc_write_cond` are decoded from state only (Moore).
  - `ir_write`, `mdr_write`, the IF-stage `pc_write` and the store retire are additionally gated by `mem_ready` in the same cycle (Mealy).
  - `pc_write` in EX (jump) is decoded from state only.
- Memory handshake:
  - `mem_req` is asserted from state entry.
  - It stays high continuously until the cycle in which `mem_ready`=1, and drops on the following edge.
  - Zero-wait memory (`mem_ready` high in the first request cycle) is legal.
- Cycle counts with zero-wait memory, from IF entry to the retire edge:
  - load 5, store 4, alur/aluimm 4, branch 3, jump 3.
  - Each memory wait cycle adds 1.
- Back-to-back instructions: with `run` held high, IF of the next instruction starts the cycle after retire, with no bubble.
- `retired` updates one edge after the final stage is entered. It is a registered output.
- Reset asserted mid-instruction (including mid-wait) aborts immediately. No partial counter update.

## Test plan
- **Reset and idle**: reset, then `run`=1 with zero-wait memory and `is_alur`=1. Required:
  - `state` sequence 0,1,2,3,5,1.
  - `reg_write` high exactly 1 cycle.
  - `retired`=1 after the WB edge.
- **Load with wait states**: `is_load`=1, `mem_ready` low for 2 cycles in IF and 3 cycles in MEM. Required:
  - `mem_req` high 3 cycles in IF and 4 cycles in MEM.
  - `ir_write` and `mdr_write` each pulse once, in their ready cycle.
  - Total 10 cycles to retire.
- **Store vs branch vs jump**, zero-wait memory. Required:
  - store: `mem_we`=1 only in MEM, no `reg_write`, 4 cycles.
  - branch: `pc_write_cond` pulses in EX, 3 cycles.
  - jump: `pc_write` pulses in IF and EX, 3 cycles.
- **Illegal class**: flags 000000 in ID, and separately `is_load`=`is_store`=1. Required:
  - `illegal`=1, `state`=6 permanently.
  - `retired` unchanged.
  - Only a reset pulse clears the condition.
- **Run drop and counter wrap**: `CNT_W`=4, execute 17 R-type instructions, drop `run` during the EX of the last one. Required:
  - The last instruction still retires.
  - `retired` reads 1 (wrap).
  - `state`=IDLE afterwards.
- **Asynchronous reset mid-MEM wait**: assert `rst_n`=0 between clock edges. Required:
  - `mem_req` falls immediately.
  - After release, the next instruction starts with `retired`=0.
